// File: rtl/rll_key_loader.sv
// rll_key_loader
//   Fetches a KEY_W-bit key from an NVM/OTP read port one WORD_W-bit word at
//   a time and checks even parity on each word. A failed attempt is retried
//   up to MAX_RETRY more times. The key is committed to key_out in a single
//   edge. key_out stays all-zero until a complete, parity-clean key is
//   committed, so the locked core never sees a partial key.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        single-cycle load command (ignored while a load is running)
//   zeroize      erases the key and returns to idle; beaten only by rst
//   nvm_req      registered read request
//   nvm_addr     registered word index, stable while nvm_req is high
//   nvm_ack      read done; nvm_data / nvm_par are valid in the same cycle
//   nvm_data     key word
//   nvm_par      even parity over nvm_data
//   key_out      committed key (bit i drives keyIn_0_i)
//   key_valid    a committed key is present
//   busy         a load is in progress
//   err          every attempt failed
//   err_code     last failure cause: 00 none, 01 parity, 10 timeout
//   state_dbg    current FSM state, for debug and checker binding
//
// NVM handshake: the loader raises nvm_req with a stable nvm_addr and keeps
// it high until it samples nvm_ack high on a rising edge, which completes the
// read. After every completed or failed request nvm_req drops for exactly one
// cycle (GAP). nvm_ack seen while nvm_req is low is ignored.
module rll_key_loader #(
  parameter int KEY_W     = 16,
  parameter int WORD_W    = 4,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255,
  localparam int NWORDS   = KEY_W / WORD_W,
  localparam int AW       = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              zeroize,
  output logic              nvm_req,
  output logic [AW-1:0]     nvm_addr,
  input  logic              nvm_ack,
  input  logic [WORD_W-1:0] nvm_data,
  input  logic              nvm_par,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [2:0]        state_dbg
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_GAP   = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [KEY_W-1:0]  shadow_q, shadow_d, shadow_cap;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              req_q;

  logic              par_bad;
  logic              last_word;
  logic              tmo_hit;
  logic              load_go;
  logic              attempt_fail;
  logic [1:0]        fail_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      shadow_q <= '0;
      key_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
      retry_q  <= '0;
      tmo_q    <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      code_q   <= code_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      // nvm_req is a flop that mirrors "next state is REQ", so it is high
      // exactly in the cycles the FSM sits in REQ.
      req_q    <= (state_d == S_REQ);
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    shadow_d     = shadow_q;
    key_d        = key_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    err_d        = err_q;
    code_d       = code_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    load_go      = 1'b0;
    attempt_fail = 1'b0;
    fail_code    = 2'b00;

    shadow_cap = shadow_q;
    shadow_cap[addr_q*WORD_W +: WORD_W] = nvm_data;
    par_bad   = ^{nvm_data, nvm_par};
    last_word = (addr_q == AW'(NWORDS - 1));
    // tmo_q counts the earlier wait cycles, so the current cycle is the
    // TIMEOUT-th one without an ack when tmo_q == TIMEOUT-1.
    tmo_hit   = !nvm_ack && (tmo_q == TW'(TIMEOUT - 1));

    case (state_q)
      S_IDLE: begin
        if (start) load_go = 1'b1;
      end
      S_REQ: begin
        if (nvm_ack) begin
          if (!par_bad) begin
            tmo_d    = '0;
            shadow_d = shadow_cap;
            if (last_word) begin
              key_d   = shadow_cap;
              valid_d = 1'b1;
              busy_d  = 1'b0;
              code_d  = 2'b00;
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_GAP;
            end
          end else begin
            attempt_fail = 1'b1;
            fail_code    = 2'b01;
          end
        end else if (tmo_hit) begin
          attempt_fail = 1'b1;
          fail_code    = 2'b10;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_REQ;
      end
      S_DONE: begin
        if (start) begin
          key_d   = '0;
          valid_d = 1'b0;
          load_go = 1'b1;
        end
      end
      S_ERROR: begin
        if (start) begin
          err_d   = 1'b0;
          load_go = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (attempt_fail) begin
      code_d = fail_code;
      tmo_d  = '0;
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d  = retry_q + 1'b1;
        addr_d   = '0;
        shadow_d = '0;
        state_d  = S_GAP;
      end else begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_ERROR;
      end
    end

    if (load_go) begin
      state_d  = S_REQ;
      addr_d   = '0;
      shadow_d = '0;
      busy_d   = 1'b1;
      retry_d  = '0;
      tmo_d    = '0;
    end

    // zeroize wins over start and over a final-word commit in the same cycle.
    if (zeroize) begin
      state_d  = S_IDLE;
      addr_d   = '0;
      shadow_d = '0;
      key_d    = '0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      err_d    = 1'b0;
      code_d   = 2'b00;
      retry_d  = '0;
      tmo_d    = '0;
    end
  end

  assign nvm_req   = req_q;
  assign nvm_addr  = addr_q;
  assign key_out   = key_q;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Testbench for rll_key_loader: NVM responder model with programmable wait
// states and one-shot parity corruption, expected keys queued at each load
// command and compared when key_valid rises.
module tb_rll_key_loader;

  localparam int KEY_W  = 16;
  localparam int WORD_W = 4;
  localparam int NWORDS = KEY_W / WORD_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              zeroize = 1'b0;
  logic              nvm_req;
  logic [1:0]        nvm_addr;
  logic              nvm_ack = 1'b0;
  logic [WORD_W-1:0] nvm_data = '0;
  logic              nvm_par = 1'b0;
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic              busy;
  logic              err;
  logic [1:0]        err_code;
  logic [2:0]        state_dbg;

  int checks = 0;
  int fails  = 0;

  logic [KEY_W-1:0]  exp_q[$];

  // NVM model
  logic [WORD_W-1:0] mem [NWORDS];
  bit                resp_en  = 1'b1;
  int                wait_n   = 0;
  bit                bad_once = 1'b0;
  int                bad_word = 2;
  int                wcnt     = 0;

  rll_key_loader #(
    .KEY_W(KEY_W), .WORD_W(WORD_W), .MAX_RETRY(3), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .zeroize(zeroize),
    .nvm_req(nvm_req), .nvm_addr(nvm_addr), .nvm_ack(nvm_ack),
    .nvm_data(nvm_data), .nvm_par(nvm_par), .key_out(key_out),
    .key_valid(key_valid), .busy(busy), .err(err), .err_code(err_code),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- NVM responder ----------------
  always @(posedge clk) begin
    #1;
    if (resp_en) begin
      if (nvm_req && wcnt == wait_n) begin
        nvm_ack  = 1'b1;
        nvm_data = mem[nvm_addr];
        nvm_par  = ^mem[nvm_addr];
        if (bad_once && int'(nvm_addr) == bad_word) begin
          nvm_par  = ~nvm_par;
          bad_once = 1'b0;
        end
        wcnt = 0;
      end else begin
        nvm_ack = 1'b0;
        if (nvm_req) wcnt++;
        else wcnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic [KEY_W-1:0] k);
    for (int i = 0; i < NWORDS; i++) mem[i] = k[i*WORD_W +: WORD_W];
  endtask

  function automatic logic [KEY_W-1:0] mem_key();
    logic [KEY_W-1:0] k;
    for (int i = 0; i < NWORDS; i++) k[i*WORD_W +: WORD_W] = mem[i];
    return k;
  endfunction

  // Returns one tick after the edge that samples start (cycle c=1).
  task automatic do_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // c counts from 1 = first cycle after the start edge.
  task automatic wait_valid(input int max_c, output int c, output bit ok);
    c = 1;
    while (!key_valid && c < max_c) begin
      tick();
      c++;
    end
    ok = key_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if ({nvm_req, nvm_addr, key_valid, busy, err, err_code} !== 8'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0", {nvm_req, nvm_addr, key_valid, busy, err, err_code});
    end
    checks++; if (key_out !== 16'h0) begin
      fails++; $display("FAIL reset_key: got %h expected 0000", key_out);
    end
    checks++; if (state_dbg !== 3'd0) begin
      fails++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    logic [KEY_W-1:0] e;
    set_mem(16'h3C5A);
    wait_n = 0;
    exp_q.push_back(mem_key());
    do_start();
    for (int c = 1; c <= 8; c++) begin
      checks++; if (nvm_req !== ((c % 2 == 1) && c <= 7)) begin
        fails++; $display("FAIL nominal_req c=%0d: got %b expected %b", c, nvm_req, (c % 2 == 1) && c <= 7);
      end
      checks++; if (key_valid !== (c == 8)) begin
        fails++; $display("FAIL nominal_valid c=%0d: got %b expected %b", c, key_valid, c == 8);
      end
      if (c == 1) begin
        checks++; if (busy !== 1'b1) begin
          fails++; $display("FAIL nominal_busy: got %b expected 1", busy);
        end
      end
      if (c < 8 && key_out !== 16'h0) begin
        checks++; fails++; $display("FAIL nominal_partial c=%0d: got %h expected 0000", c, key_out);
      end
      if (c < 8) tick();
    end
    e = exp_q.pop_front();
    checks++; if (key_out !== e) begin
      fails++; $display("FAIL nominal_key: got %h expected %h", key_out, e);
    end
    checks++; if ({err, busy, err_code} !== 4'b0) begin
      fails++; $display("FAIL nominal_status: got %b expected 0000", {err, busy, err_code});
    end
  endtask

  task automatic test_reload();
    logic [KEY_W-1:0] e;
    int c;
    bit ok;
    set_mem(16'hFFFF);
    exp_q.push_back(mem_key());
    do_start();
    checks++; if ({key_valid, key_out} !== 17'h0) begin
      fails++; $display("FAIL reload_clear: got valid=%b key=%h expected 0/0000", key_valid, key_out);
    end
    wait_valid(40, c, ok);
    checks++; if (!ok || c != 8) begin
      fails++; $display("FAIL reload_latency: got %0d (valid=%b) expected 8", c, ok);
    end
    e = exp_q.pop_front();
    checks++; if (key_out !== e) begin
      fails++; $display("FAIL reload_key: got %h expected %h", key_out, e);
    end
  endtask

  task automatic test_wait_states();
    logic [KEY_W-1:0] e;
    int c;
    bit ok;
    set_mem(16'h96E1);
    wait_n = 2;
    exp_q.push_back(mem_key());
    do_start();
    wait_valid(60, c, ok);
    checks++; if (!ok || c != 2 * NWORDS + NWORDS * 2) begin
      fails++; $display("FAIL wait_latency: got %0d (valid=%b) expected %0d", c, ok, 2 * NWORDS + NWORDS * 2);
    end
    e = exp_q.pop_front();
    checks++; if (key_out !== e) begin
      fails++; $display("FAIL wait_key: got %h expected %h", key_out, e);
    end
    wait_n = 0;
  endtask

  task automatic test_parity_retry();
    logic [KEY_W-1:0] e;
    int c;
    bit ok;
    set_mem(16'h3C5A);
    bad_once = 1'b1;
    bad_word = 2;
    exp_q.push_back(mem_key());
    do_start();
    c = 0;
    while (err_code !== 2'b01 && c < 30) begin
      tick();
      c++;
    end
    checks++; if (err_code !== 2'b01) begin
      fails++; $display("FAIL parity_code: got %b expected 01", err_code);
    end
    checks++; if ({nvm_req, nvm_addr} !== 3'b000) begin
      fails++; $display("FAIL parity_gap: got req=%b addr=%0d expected 0/0", nvm_req, nvm_addr);
    end
    tick();
    checks++; if ({nvm_req, nvm_addr, err_code} !== 5'b1_00_01) begin
      fails++; $display("FAIL parity_restart: got req=%b addr=%0d code=%b expected 1/0/01", nvm_req, nvm_addr, err_code);
    end
    wait_valid(40, c, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || key_out !== e) begin
      fails++; $display("FAIL parity_key: got %h (valid=%b) expected %h", key_out, ok, e);
    end
    checks++; if (err_code !== 2'b00 || err !== 1'b0) begin
      fails++; $display("FAIL parity_final: got code=%b err=%b expected 00/0", err_code, err);
    end
  endtask

  task automatic test_zeroize();
    logic [KEY_W-1:0] e;
    int c;
    bit ok;
    set_mem(16'h3C5A);
    wait_n = 1;
    do_start();
    c = 0;
    while (!(nvm_req && nvm_addr == 2'd1) && c < 30) begin
      tick();
      c++;
    end
    zeroize = 1'b1;
    start   = 1'b1;
    tick();
    zeroize = 1'b0;
    start   = 1'b0;
    checks++; if (state_dbg !== 3'd0 || nvm_req !== 1'b0) begin
      fails++; $display("FAIL zeroize_idle: got state=%0d req=%b expected 0/0", state_dbg, nvm_req);
    end
    checks++; if ({key_out, key_valid, busy, err, err_code, nvm_addr} !== 23'h0) begin
      fails++; $display("FAIL zeroize_outputs: got key=%h v=%b b=%b e=%b code=%b addr=%0d expected all 0",
                        key_out, key_valid, busy, err, err_code, nvm_addr);
    end
    tick();
    checks++; if (state_dbg !== 3'd0 || nvm_req !== 1'b0) begin
      fails++; $display("FAIL zeroize_hold: got state=%0d req=%b expected 0/0", state_dbg, nvm_req);
    end
    wait_n = 0;
    exp_q.push_back(mem_key());
    do_start();
    wait_valid(40, c, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || c != 8 || key_out !== e) begin
      fails++; $display("FAIL zeroize_reload: got key=%h c=%0d valid=%b expected %h at 8", key_out, c, ok, e);
    end
  endtask

  task automatic test_timeout_exhaust();
    int c;
    resp_en = 1'b0;
    nvm_ack = 1'b0;
    do_start();
    c = 1;
    while (err_code !== 2'b10 && c < 300) begin
      tick();
      c++;
    end
    checks++; if (c != 256 || err_code !== 2'b10) begin
      fails++; $display("FAIL timeout_first: got cycle %0d code=%b expected 256/10", c, err_code);
    end
    checks++; if (nvm_req !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
      fails++; $display("FAIL timeout_gap: got req=%b busy=%b err=%b expected 0/1/0", nvm_req, busy, err);
    end
    tick();
    c++;
    checks++; if (nvm_req !== 1'b1) begin
      fails++; $display("FAIL timeout_retry_req: got %b expected 1", nvm_req);
    end
    while (!err && c < 1200) begin
      tick();
      c++;
    end
    checks++; if (!err || c != 1024) begin
      fails++; $display("FAIL timeout_err_cycle: got %0d (err=%b) expected 1024", c, err);
    end
    checks++; if ({err_code, busy, key_valid, nvm_req} !== 5'b10_000 || key_out !== 16'h0) begin
      fails++; $display("FAIL timeout_status: got code=%b busy=%b v=%b req=%b key=%h expected 10/0/0/0/0000",
                        err_code, busy, key_valid, nvm_req, key_out);
    end
    checks++; if (state_dbg !== 3'd4) begin
      fails++; $display("FAIL timeout_state: got %0d expected 4", state_dbg);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    logic [KEY_W-1:0] e;
    int c;
    bit ok;
    set_mem(16'h3C5A);
    wait_n = 0;
    do_start();
    checks++; if (err !== 1'b0 || err_code !== 2'b10 || busy !== 1'b1) begin
      fails++; $display("FAIL restart_from_error: got err=%b code=%b busy=%b expected 0/10/1", err, err_code, busy);
    end
    tick();
    checks++; if (state_dbg !== 3'd2) begin
      fails++; $display("FAIL rst_gap_reached: got state %0d expected 2", state_dbg);
    end
    rst     = 1'b1;
    resp_en = 1'b0;
    nvm_ack = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if ({nvm_req, nvm_addr, key_valid, busy, err, err_code} !== 8'b0 || key_out !== 16'h0) begin
      fails++; $display("FAIL rst_mid_outputs: got ctrl=%b key=%h expected 0", {nvm_req, nvm_addr, key_valid, busy, err, err_code}, key_out);
    end
    nvm_ack  = 1'b1;
    nvm_data = 4'hF;
    nvm_par  = 1'b0;
    repeat (3) tick();
    nvm_ack = 1'b0;
    checks++; if (state_dbg !== 3'd0 || {nvm_req, key_valid, busy} !== 3'b0 || key_out !== 16'h0) begin
      fails++; $display("FAIL late_ack_ignored: got state=%0d req=%b v=%b busy=%b key=%h expected idle, all 0",
                        state_dbg, nvm_req, key_valid, busy, key_out);
    end
    resp_en = 1'b1;
    exp_q.push_back(mem_key());
    do_start();
    wait_valid(40, c, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || c != 8 || key_out !== e) begin
      fails++; $display("FAIL post_rst_load: got key=%h c=%0d valid=%b expected %h at 8", key_out, c, ok, e);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_mem(16'h0);
    test_reset();
    test_nominal();
    test_reload();
    test_wait_states();
    test_parity_retry();
    test_zeroize();
    test_timeout_exhaust();
    test_reset_mid_load();
    checks++; if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rll_key_loader.md
# rll_key_loader

Sequential key-delivery stage that sits directly upstream of the RLL-16 locked combinational netlists and drives their 16 `keyIn_0_*` inputs. The loader fetches the key from an on-chip NVM/OTP port over a request/acknowledge handshake, one word at a time, and checks per-word parity. It retries failed loads, then commits the key atomically. Until a valid key is committed, the locked core sees an all-zero key.

## Interface
- `KEY_W`, 16, key width; must equal the lock's key-bit count and be a multiple of `WORD_W`
- `WORD_W`, 4, NVM word width; `NWORDS = KEY_W/WORD_W`
- `MAX_RETRY`, 3, retries after the first failed attempt; total attempts are `1+MAX_RETRY`
- `TIMEOUT`, 255, maximum number of cycles `nvm_req` may stay high without `nvm_ack`

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle load command
- `zeroize`  in  1  erases the key; highest priority after `rst`
- `nvm_req`  out  1  read request, registered
- `nvm_addr`  out  clog2(NWORDS)  word index, registered; stable while `nvm_req` is high
- `nvm_ack`  in  1  read done; `nvm_data`/`nvm_par` are valid in the same cycle
- `nvm_data`  in  WORD_W  key word
- `nvm_par`  in  1  even parity over `nvm_data`
- `key_out`  out  KEY_W  bit i drives `keyIn_0_i`; all zeros unless `key_valid` is high
- `key_valid`  out  1  a committed key is present
- `busy`  out  1  a load is in progress
- `err`  out  1  all attempts have failed
- `err_code`  out  2  cause of the last failure: 00 none, 01 parity, 10 timeout

## Operation
States: IDLE, REQ, GAP, DONE, ERROR.
- **IDLE**
  - `start` moves the FSM to REQ with addr=0, `busy`=1, retry count=0, shadow register cleared.
- **REQ**
  - `nvm_req`=1. The timeout counter increments every cycle without `nvm_ack`.
  - On a cycle with `nvm_ack` sampled high, capture `nvm_data` into shadow bits `[addr*WORD_W +: WORD_W]` and check `^{nvm_data,nvm_par}==0`.
  - Parity good, not the last word: go to GAP, addr+1, timeout counter cleared.
  - Parity good, last word: copy shadow to `key_out`, set `key_valid`=1, `busy`=0, `err_code`=00, go to DONE.
  - Parity bad, or timeout counter reaches `TIMEOUT`: the attempt fails. Record `err_code`.
    - If retry count < `MAX_RETRY`: increment it, clear addr and shadow, go to GAP.
    - Otherwise: go to ERROR with `err`=1 and `busy`=0.
- **GAP**
  - `nvm_req`=0 for exactly one cycle, then return to REQ.
- **DONE**
  - Holds the key.
  - `start` reloads: in the same edge, clear `key_out` to 0 and `key_valid` to 0, then proceed as from IDLE.
- **ERROR**
  - `key_out`=0.
  - `start` clears `err` and restarts as from IDLE; `err_code` holds until the next failure or success.
- **`start` while busy** (REQ/GAP) is ignored.
- **`zeroize`** in any state returns the FSM to IDLE on the next edge.
  - Clears `key_out`, shadow, `key_valid`, `err`, `err_code`, `busy`, `nvm_req`, and the counters.
  - Overrides a simultaneous `start` or a simultaneous final-word commit.
- **`nvm_ack` outside REQ** is ignored.
- **Partial keys never reach `key_out`.** The shadow register is internal only.

## Timing
- Reset values: every output is 0 and the state is IDLE. `rst` overrides `zeroize` and `start`.
- `start` sampled at edge t gives `nvm_req`=1 in cycle t+1.
- With a zero-wait `nvm_ack`:
  - `nvm_req` is high in cycles t+1, t+3, t+5, t+7.
  - `key_valid` rises in cycle t+8, i.e. 2·NWORDS cycles after `start`.
- Each NVM wait cycle adds one cycle of latency.
- Timeout: a failure is declared at the edge where the req-high-without-ack count equals `TIMEOUT`. With `TIMEOUT`=255, a request first raised in cycle r fails at the end of cycle r+254.
- A retry's first request is high 2 cycles after the failing edge.
- `key_out` and `key_valid` change together on one edge; there is no glitch window.

## Test plan
- **Nominal load:** NVM words 0..3 = 4'hA, 4'h5, 4'hC, 4'h3 with correct parity, zero-wait ack → `key_out`=16'h3C5A, `key_valid` rises 8 cycles after `start`, `err`=0.
- **Parity retry:** word 2 has bad parity on the first attempt only → `nvm_addr` restarts at 0, `err_code`=01 during the retry, final `key_out`=16'h3C5A, `err_code`=00.
- **Exhausted retries:** `nvm_ack` never asserted → 4 attempts, each failing after 255 request cycles; then `err`=1, `err_code`=10, `key_out`=0, `busy`=0.
- **Zeroize mid-load:** `zeroize` during word 1, coincident with `start` → next cycle IDLE, `nvm_req`=0, all outputs 0; the later `start` loads normally.
- **Reload from DONE:** `start` in DONE with NVM now holding 16'hFFFF → `key_valid`/`key_out` go to 0 the next cycle, then `key_out`=16'hFFFF after 8 cycles.
- **Reset mid-load:** `rst` asserted during GAP → all outputs 0 the next cycle; a late `nvm_ack` arriving afterwards is ignored.
